// File: rtl/cmd_frame_pkg.sv
// rtl/cmd_frame_pkg.sv - shared constants, state encoding and request decode for the command frame parser
package cmd_frame_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         REQ_W        = 11;

  localparam logic [7:0] CMD_WRITE_ONLY         = 8'h00;
  localparam logic [7:0] CMD_POWERON            = 8'h01;
  localparam logic [7:0] CMD_POWEROFF           = 8'h02;
  localparam logic [7:0] CMD_UP                 = 8'h03;
  localparam logic [7:0] CMD_DOWN               = 8'h04;
  localparam logic [7:0] CMD_SHAKE_BF_PASS      = 8'h05;
  localparam logic [7:0] CMD_SHAKE_BT_PASS      = 8'h06;
  localparam logic [7:0] CMD_PRINT              = 8'h07;
  localparam logic [7:0] CMD_FILL_ZEROS         = 8'h08;
  localparam logic [7:0] CMD_FILL_ONES          = 8'h09;
  localparam logic [7:0] CMD_SHAKE_BF_PASS_UP   = 8'h0A;
  localparam logic [7:0] CMD_SHAKE_BF_PASS_DOWN = 8'h0B;
  localparam logic [7:0] CMD_MAX                = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_REPLAY,
    ST_FIRE
  } state_e;

  // CMD n maps to request bit n-1; write-only and out-of-range codes map to no request.
  function automatic logic [REQ_W-1:0] cmd_to_req(input logic [7:0] cmd);
    logic [REQ_W-1:0] r;
    r = '0;
    for (int i = 0; i < REQ_W; i++) begin
      if (cmd == 8'(i + 1)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmd_payload_buf.sv
// rtl/cmd_payload_buf.sv - payload byte store with write pointer and pair-wise read index
module cmd_payload_buf #(
  parameter int MAX_PAIRS = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr_i,
  input  logic                               wr_en_i,
  input  logic [7:0]                         wr_data_i,
  input  logic                               rd_adv_i,
  output logic [$clog2(2*MAX_PAIRS+1)-1:0]   wr_cnt_o,
  output logic [$clog2(MAX_PAIRS+1)-1:0]     rd_idx_o,
  output logic [7:0]                         rd_addr_o,
  output logic [7:0]                         rd_data_o
);

  localparam int DEPTH = 2 * MAX_PAIRS;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int RW    = $clog2(MAX_PAIRS + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [RW-1:0] rd_idx_q;
  logic [AW-1:0] ra_lo;
  logic [AW-1:0] ra_hi;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr_q <= '0;
    end else if (wr_en_i && (int'(wr_ptr_q) < DEPTH)) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  // Storage is not reset: only bytes written since the last clear are ever read.
  always_ff @(posedge clk) begin
    if (wr_en_i && (int'(wr_ptr_q) < DEPTH)) begin
      mem_q[AW'(wr_ptr_q)] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      rd_idx_q <= '0;
    end else if (rd_adv_i) begin
      rd_idx_q <= rd_idx_q + 1'b1;
    end
  end

  assign ra_lo     = AW'({rd_idx_q, 1'b0});
  assign ra_hi     = ra_lo | AW'(1);
  assign rd_addr_o = mem_q[ra_lo];
  assign rd_data_o = mem_q[ra_hi];
  assign wr_cnt_o  = wr_ptr_q;
  assign rd_idx_o  = rd_idx_q;

endmodule

// File: rtl/cmd_frame_parser.sv
// rtl/cmd_frame_parser.sv - framed command parser replaying checked register writes; optional CMD_TIMEOUT_EN
module cmd_frame_parser
  import cmd_frame_pkg::*;
#(
  parameter int         MAX_PAIRS   = 16,
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       w_addr_o,
  output logic             w_wren_o,
  output logic [7:0]       w_data_o,
  output logic [REQ_W-1:0] req_o,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [7:0]       err_cnt
);

  localparam int DEPTH = 2 * MAX_PAIRS;
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int RW    = $clog2(MAX_PAIRS + 1);

  state_e           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       chk_q, chk_d;
  logic [7:0]       w_addr_q, w_addr_d;
  logic [7:0]       w_data_q, w_data_d;
  logic             w_wren_q, w_wren_d;
  logic [REQ_W-1:0] req_q, req_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             accept;
  logic             tmo_hit;
  logic             buf_clr;
  logic             buf_wr;
  logic             buf_rd_adv;
  logic [PW-1:0]    buf_wr_cnt;
  logic [RW-1:0]    buf_rd_idx;
  logic [7:0]       buf_rd_addr;
  logic [7:0]       buf_rd_data;

  assign rx_ready = !rst && (state_q != ST_REPLAY) && (state_q != ST_FIRE);
  assign accept   = rx_valid && rx_ready;

  cmd_payload_buf #(
    .MAX_PAIRS (MAX_PAIRS)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (buf_clr),
    .wr_en_i   (buf_wr),
    .wr_data_i (rx_data),
    .rd_adv_i  (buf_rd_adv),
    .wr_cnt_o  (buf_wr_cnt),
    .rd_idx_o  (buf_rd_idx),
    .rd_addr_o (buf_rd_addr),
    .rd_data_o (buf_rd_data)
  );

`ifdef CMD_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        in_frame;

  assign in_frame = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                    (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  assign tmo_hit  = in_frame && !accept && (tmo_q == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || accept || !in_frame || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 32'd1;
    end
  end
`else
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT_CYC == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    chk_d      = chk_q;
    w_addr_d   = '0;
    w_data_d   = '0;
    w_wren_d   = 1'b0;
    req_d      = '0;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    buf_clr    = 1'b0;
    buf_wr     = 1'b0;
    buf_rd_adv = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept && (rx_data == SYNC_BYTE)) begin
          buf_clr = 1'b1;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (accept) begin
          if (rx_data > CMD_MAX) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cmd_d   = rx_data;
            chk_d   = rx_data;
            state_d = ST_LEN;
          end
        end
      end
      ST_LEN: begin
        if (accept) begin
          len_d = rx_data;
          chk_d = chk_q ^ rx_data;
          if (rx_data[0] || (int'(rx_data) > DEPTH)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (rx_data == 8'd0) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          buf_wr = 1'b1;
          chk_d  = chk_q ^ rx_data;
          if (int'(buf_wr_cnt) + 1 == int'(len_q)) state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (accept) begin
          if (rx_data != chk_q) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (len_q == 8'd0) begin
            req_d   = cmd_to_req(cmd_q);
            ok_d    = 1'b1;
            state_d = ST_FIRE;
          end else begin
            // Pair 0 is loaded here so it appears the cycle right after the checksum byte.
            w_wren_d   = 1'b1;
            w_addr_d   = buf_rd_addr;
            w_data_d   = buf_rd_data;
            buf_rd_adv = 1'b1;
            state_d    = ST_REPLAY;
          end
        end
      end
      ST_REPLAY: begin
        if (int'(buf_rd_idx) == int'(len_q >> 1)) begin
          req_d   = cmd_to_req(cmd_q);
          ok_d    = 1'b1;
          state_d = ST_FIRE;
        end else begin
          w_wren_d   = 1'b1;
          w_addr_d   = buf_rd_addr;
          w_data_d   = buf_rd_data;
          buf_rd_adv = 1'b1;
        end
      end
      ST_FIRE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (tmo_hit) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end

    err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      len_q     <= '0;
      chk_q     <= '0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      w_wren_q  <= 1'b0;
      req_q     <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      chk_q     <= chk_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      w_wren_q  <= w_wren_d;
      req_q     <= req_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign w_addr_o  = w_addr_q;
  assign w_data_o  = w_data_q;
  assign w_wren_o  = w_wren_q;
  assign req_o     = req_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// tb/tb_cmd_frame_parser.sv - directed and randomized frame checks against a stream-level reference parser
module tb_cmd_frame_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  w_addr_o;
  logic        w_wren_o;
  logic [7:0]  w_data_o;
  logic [10:0] req_o;
  logic        frame_ok;
  logic        frame_err;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  cmd_frame_parser #(
    .MAX_PAIRS   (16),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .w_addr_o  (w_addr_o),
    .w_wren_o  (w_wren_o),
    .w_data_o  (w_data_o),
    .req_o     (req_o),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  typedef struct { logic [7:0] a; logic [7:0] d; int c; } wr_t;
  typedef struct { logic [10:0] r; int c; } rq_t;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  wr_t  wr_q[$];
  rq_t  rq_q[$];
  int   ok_q[$];
  int   rdy_low[$];
  int   err_ev;
  int   last_acc;
  wr_t  mw;
  rq_t  mr;

  logic [7:0]  stim[$];
  wr_t         exp_wr[$];
  logic [10:0] exp_rq[$];
  int          exp_ok;
  int          exp_err;
  int          err_model;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (w_wren_o) begin
        mw.a = w_addr_o; mw.d = w_data_o; mw.c = cyc;
        wr_q.push_back(mw);
      end
      if (req_o != 11'd0) begin
        mr.r = req_o; mr.c = cyc;
        rq_q.push_back(mr);
      end
      if (frame_ok) ok_q.push_back(cyc);
      if (frame_err) err_ev++;
      if (!rx_ready) rdy_low.push_back(cyc);
      if (rx_valid && rx_ready) last_acc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    wr_q.delete(); rq_q.delete(); ok_q.delete(); rdy_low.delete();
    err_ev = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_stim(input bit gaps);
    foreach (stim[i]) begin
      send_byte(stim[i]);
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  // Reference parser: walks the byte list frame by frame using the framing rules directly.
  task automatic model_run();
    int i, n, len;
    logic [7:0] cmd, x;
    wr_t w;
    i = 0; n = stim.size();
    exp_wr.delete(); exp_rq.delete(); exp_ok = 0; exp_err = 0;
    while (i < n) begin
      if (stim[i] != 8'hA5) begin i++; continue; end
      i++;
      if (i >= n) break;
      cmd = stim[i]; i++;
      if (cmd > 8'd11) begin exp_err++; continue; end
      if (i >= n) break;
      len = int'(stim[i]); i++;
      if ((len % 2) != 0 || len > 32) begin exp_err++; continue; end
      if (i + len >= n) break;
      x = cmd ^ 8'(len);
      for (int k = 0; k < len; k++) x ^= stim[i + k];
      if (x != stim[i + len]) begin
        exp_err++;
      end else begin
        for (int p = 0; p < len / 2; p++) begin
          w.a = stim[i + 2*p]; w.d = stim[i + 2*p + 1]; w.c = 0;
          exp_wr.push_back(w);
        end
        if (cmd != 8'd0) exp_rq.push_back(11'd1 << (cmd - 8'd1));
        exp_ok++;
      end
      i += len + 1;
    end
    err_model = (err_model + exp_err > 255) ? 255 : err_model + exp_err;
  endtask

  task automatic compare(input string tag);
    chk({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int k = 0; k < wr_q.size() && k < exp_wr.size(); k++)
      chk($sformatf("%s_wr%0d", tag, k), {16'd0, wr_q[k].a, wr_q[k].d}, {16'd0, exp_wr[k].a, exp_wr[k].d});
    chk({tag, "_nreq"}, 32'(rq_q.size()), 32'(exp_rq.size()));
    for (int k = 0; k < rq_q.size() && k < exp_rq.size(); k++)
      chk($sformatf("%s_req%0d", tag, k), 32'(rq_q[k].r), 32'(exp_rq[k]));
    chk({tag, "_nok"}, 32'(ok_q.size()), 32'(exp_ok));
    chk({tag, "_nerr"}, 32'(err_ev), 32'(exp_err));
    chk({tag, "_errcnt"}, 32'(err_cnt), 32'(err_model));
  endtask

  task automatic run_stream(input string tag, input bit gaps);
    clr_mon();
    model_run();
    send_stim(gaps);
    idle(40);
    compare(tag);
  endtask

  task automatic gen_frame(input int kind);
    logic [7:0] b, cmd, len, x;
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h00;
      stim.push_back(b);
    end
    stim.push_back(8'hA5);
    cmd = (kind == 1) ? 8'($urandom_range(12, 255)) : 8'($urandom_range(0, 11));
    stim.push_back(cmd);
    if (kind == 1) return;
    if (kind == 2) len = ($urandom_range(0, 1) == 0) ? 8'(2*$urandom_range(0, 15) + 1) : 8'($urandom_range(33, 255));
    else len = 8'(2 * $urandom_range(0, 16));
    stim.push_back(len);
    if (kind == 2) return;
    x = cmd ^ len;
    for (int k = 0; k < int'(len); k++) begin
      b = 8'($urandom_range(0, 255));
      x ^= b;
      stim.push_back(b);
    end
    if (kind == 3) x ^= 8'($urandom_range(1, 255));
    stim.push_back(x);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; err_model = 0; err_ev = 0; last_acc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wren", 32'(w_wren_o), 32'd0);
    chk("rst_addr_data", {16'd0, w_addr_o, w_data_o}, 32'd0);
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_ok_err", {30'd0, frame_ok, frame_err}, 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    chk("rst_ready", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;

    stim = '{8'hA5, 8'h03, 8'h00, 8'h03};
    run_stream("t1", 1'b0);
    if (rq_q.size() > 0) chk("t1_req_cyc", 32'(rq_q[0].c), 32'(last_acc + 1));
    if (ok_q.size() > 0) chk("t1_ok_cyc", 32'(ok_q[0]), 32'(last_acc + 1));
    chk("t1_rdy_low_n", 32'(rdy_low.size()), 32'd1);
    if (rdy_low.size() > 0) chk("t1_rdy_low_cyc", 32'(rdy_low[0]), 32'(last_acc + 1));

    stim = '{8'hA5, 8'h00, 8'h04, 8'h12, 8'h34, 8'h85, 8'h40, 8'hE7};
    run_stream("t2", 1'b0);
    if (wr_q.size() > 1) begin
      chk("t2_wr0_cyc", 32'(wr_q[0].c), 32'(last_acc + 1));
      chk("t2_wr1_cyc", 32'(wr_q[1].c), 32'(last_acc + 2));
    end
    if (ok_q.size() > 0) chk("t2_ok_cyc", 32'(ok_q[0]), 32'(last_acc + 3));

    stim = '{8'hA5, 8'h02, 8'h02, 8'h10, 8'h55, 8'h00};
    run_stream("t3bad", 1'b0);
    stim = '{8'hA5, 8'h02, 8'h02, 8'h10, 8'h55, 8'h45};
    run_stream("t3good", 1'b0);

    stim = '{8'hA5, 8'h05, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hA5, 8'h08, 8'h00, 8'h08};
    run_stream("t4", 1'b1);

    for (int s = 0; s < 5; s++) begin
      stim.delete();
      for (int f = 0; f < 5; f++) gen_frame(($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3)));
      run_stream($sformatf("rnd%0d", s), 1'b1);
    end

    // Reset in the middle of a 16-pair replay, right after the third write.
    clr_mon();
    stim = '{8'hA5, 8'h01, 8'h20};
    begin
      logic [7:0] x, b;
      x = 8'h01 ^ 8'h20;
      for (int k = 0; k < 32; k++) begin b = 8'($urandom_range(0, 255)); x ^= b; stim.push_back(b); end
      stim.push_back(x);
    end
    send_stim(1'b0);
    begin
      int n;
      n = 0;
      while (wr_q.size() < 3 && n < 100) begin @(negedge clk); #1; n++; end
      chk("t5_reached_pair3", 32'(wr_q.size()), 32'd3);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_outs", {11'd0, w_wren_o, frame_ok, frame_err, req_o}, 32'd0);
    chk("t5_rst_addr_data_cnt", {8'd0, w_addr_o, w_data_o, err_cnt}, 32'd0);
    chk("t5_rst_ready", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    err_model = 0;
    idle(40);
    chk("t5_nwr_after_rst", 32'(wr_q.size()), 32'd3);
    chk("t5_no_req_ok_err", 32'(rq_q.size() + ok_q.size() + err_ev), 32'd0);
    stim = '{8'hA5, 8'h0B, 8'h02, 8'hF0, 8'h0F, 8'h0B};
    run_stream("t5next", 1'b0);

    stim.delete();
    for (int k = 0; k < 256; k++) begin stim.push_back(8'hA5); stim.push_back(8'h0C); end
    run_stream("t5sat", 1'b0);

`ifdef CMD_TIMEOUT_EN
    clr_mon();
    send_byte(8'hA5); send_byte(8'h03);
    idle(60);
    err_model = (err_model == 255) ? 255 : err_model + 1;
    chk("t6_tmo_err", 32'(err_ev), 32'd1);
    chk("t6_tmo_errcnt", 32'(err_cnt), 32'(err_model));
    stim = '{8'hA5, 8'h03, 8'h00, 8'h03};
    run_stream("t6after", 1'b0);
`else
    clr_mon();
    stim = '{8'hA5, 8'h03, 8'h00, 8'h03};
    model_run();
    send_byte(8'hA5); send_byte(8'h03);
    idle(1000);
    send_byte(8'h00); send_byte(8'h03);
    idle(20);
    compare("t6");
    if (rq_q.size() > 0) chk("t6_req_val", 32'(rq_q[0].r), 32'h004);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
